// File: rtl/bomb_controller.sv
// Bomb controller: owns the player's single bomb from drop to detonation.
// Latches a grid-snapped bomb position, runs the fuse and blast timers,
// issues a one-cycle explosion strobe with a stable blast centre, and
// produces bomb / plus-shaped blast pixel flags for the display mux.
module bomb_controller #(
    parameter int TICK_LIMIT    = 25000000,
    parameter int FUSE_TICKS    = 8,
    parameter int EXPLODE_TICKS = 4,
    parameter int TILE          = 16,
    parameter int GRID_X0       = 143,
    parameter int GRID_Y0       = 34,
    parameter int ARM_NEG       = 48,
    parameter int ARM_POS       = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_drop,
    input  logic       game_over,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] v_x,
    input  logic [9:0] v_y,
    output logic [9:0] e_x,
    output logic [9:0] e_y,
    output logic       explosion_SCEN,
    output logic       bomb_active,
    output logic       blast_active,
    output logic       bomb_on,
    output logic       blast_on
);

    localparam int TICK_W  = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
    localparam int MAX_TK  = (FUSE_TICKS > EXPLODE_TICKS) ? FUSE_TICKS : EXPLODE_TICKS;
    localparam int TCNT_W  = $clog2(MAX_TK + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DETONATE = 2'd2,
        BLAST    = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                btn_drop_q;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic [TCNT_W-1:0]   tick_count_reg;
    logic [9:0]          e_x_reg, e_y_reg;

    logic                drop_req;
    logic                tick;
    logic                load_pos;
    logic [9:0]          dx, dy, snap_x, snap_y;

    assign drop_req = btn_drop & ~btn_drop_q;
    assign tick     = (tick_cnt_reg == TICK_W'(TICK_LIMIT - 1));
    assign load_pos = (state_reg == IDLE) & drop_req & ~game_over;

    // Round the player's top-left corner to the nearest tile origin (10-bit wrap arithmetic).
    assign dx     = b_x - 10'(GRID_X0);
    assign dy     = b_y - 10'(GRID_Y0);
    assign snap_x = ((dx + 10'(TILE / 2)) & ~10'(TILE - 1)) + 10'(GRID_X0);
    assign snap_y = ((dy + 10'(TILE / 2)) & ~10'(TILE - 1)) + 10'(GRID_Y0);

    // Next-state logic; game_over overrides everything, including a drop or detonation.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:     if (drop_req) state_next = ARMED;
            ARMED:    if (tick && tick_count_reg == TCNT_W'(FUSE_TICKS - 1)) state_next = DETONATE;
            DETONATE: state_next = BLAST;
            BLAST:    if (tick && tick_count_reg == TCNT_W'(EXPLODE_TICKS - 1)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (game_over) state_next = IDLE;
    end

    // State register and drop-button edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            btn_drop_q <= 1'b0;
        end else begin
            state_reg  <= state_next;
            btn_drop_q <= btn_drop;
        end
    end

    // Tick prescaler and tick count, both restarted whenever a new state is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg   <= '0;
            tick_count_reg <= '0;
        end else if (state_next != state_reg) begin
            tick_cnt_reg   <= '0;
            tick_count_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg   <= '0;
            tick_count_reg <= tick_count_reg + 1'b1;
        end else begin
            tick_cnt_reg   <= tick_cnt_reg + 1'b1;
        end
    end

    // Blast centre is captured only on an accepted drop and held until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_x_reg <= 10'(GRID_X0);
            e_y_reg <= 10'(GRID_Y0);
        end else if (load_pos) begin
            e_x_reg <= snap_x;
            e_y_reg <= snap_y;
        end
    end

    assign e_x            = e_x_reg;
    assign e_y            = e_y_reg;
    assign explosion_SCEN = (state_reg == DETONATE);
    assign bomb_active    = (state_reg == ARMED);
    assign blast_active   = (state_reg == BLAST);

    // Pixel decode in 11 bits, with the arm offset added to the pixel side so no
    // subtraction from e_x/e_y can wrap near the left/top walls.
    logic [10:0] vx11, vy11, ex11, ey11;
    logic        in_col, in_row, h_arm, v_arm;

    assign vx11 = {1'b0, v_x};
    assign vy11 = {1'b0, v_y};
    assign ex11 = {1'b0, e_x_reg};
    assign ey11 = {1'b0, e_y_reg};

    assign in_col = (vx11 >= ex11) && (vx11 <= ex11 + 11'(TILE - 1));
    assign in_row = (vy11 >= ey11) && (vy11 <= ey11 + 11'(TILE - 1));
    assign h_arm  = (vx11 + 11'(ARM_NEG) >= ex11) && (vx11 <= ex11 + 11'(ARM_POS)) && in_row;
    assign v_arm  = (vy11 + 11'(ARM_NEG) >= ey11) && (vy11 <= ey11 + 11'(ARM_POS)) && in_col;

    assign bomb_on  = bomb_active & in_col & in_row;
    assign blast_on = blast_active & (h_arm | v_arm);

endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller with short timers (TICK_LIMIT=4,
// FUSE_TICKS=3, EXPLODE_TICKS=2). Expected values are hand-computed.
module tb_bomb_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_drop;
    logic       game_over;
    logic [9:0] b_x, b_y, v_x, v_y;
    logic [9:0] e_x, e_y;
    logic       explosion_SCEN, bomb_active, blast_active, bomb_on, blast_on;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int strobes;

    bomb_controller #(
        .TICK_LIMIT(4), .FUSE_TICKS(3), .EXPLODE_TICKS(2), .TILE(16),
        .GRID_X0(143), .GRID_Y0(34), .ARM_NEG(48), .ARM_POS(63)
    ) dut (
        .clk(clk), .reset(reset), .btn_drop(btn_drop), .game_over(game_over),
        .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
        .e_x(e_x), .e_y(e_y), .explosion_SCEN(explosion_SCEN),
        .bomb_active(bomb_active), .blast_active(blast_active),
        .bomb_on(bomb_on), .blast_on(blast_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic exp);
        v_x = 10'(x);
        v_y = 10'(y);
        #1;
        check(tag, {9'd0, blast_on}, {9'd0, exp});
    endtask

    initial begin
        reset = 1'b1; btn_drop = 1'b0; game_over = 1'b0;
        b_x = 10'd0; b_y = 10'd0; v_x = 10'd0; v_y = 10'd0;
        step(); step();
        reset = 1'b0;

        // Reset and idle for 20 cycles.
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (explosion_SCEN) strobes++;
        end
        check("rst_e_x", e_x, 10'd143);
        check("rst_e_y", e_y, 10'd34);
        check("rst_bomb", {9'd0, bomb_active}, 10'd0);
        check("rst_blast", {9'd0, blast_active}, 10'd0);
        check("rst_strobes", 10'(strobes), 10'd0);
        $display("idle: e_x=%0d e_y=%0d strobes=%0d", e_x, e_y, strobes);

        // Drop at (150,60), button held for 40 cycles: full cycle-exact timeline.
        b_x = 10'd150; b_y = 10'd60;
        btn_drop = 1'b1;
        step();                      // edge k accepted the drop; now in cycle k+1
        strobes = 0;
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("bomb_c%0d", c), {9'd0, bomb_active}, {9'd0, (c >= 1 && c <= 12)});
            check($sformatf("scen_c%0d", c), {9'd0, explosion_SCEN}, {9'd0, (c == 13)});
            check($sformatf("blast_c%0d", c), {9'd0, blast_active}, {9'd0, (c >= 14 && c <= 21)});
            if (explosion_SCEN) begin
                strobes++;
                check("scen_e_x", e_x, 10'd143);
                check("scen_e_y", e_y, 10'd66);
            end
            if (c == 2) begin
                v_x = 10'd143; v_y = 10'd66; #1;
                check("bomb_on_in", {9'd0, bomb_on}, 10'd1);
                v_x = 10'd159; #1;
                check("bomb_on_out", {9'd0, bomb_on}, 10'd0);
            end
            if (c == 14) begin
                pix("blast_206_70", 206, 70, 1'b1);
                pix("blast_143_129", 143, 129, 1'b1);
                pix("blast_207_70", 207, 70, 1'b0);
                pix("blast_160_82", 160, 82, 1'b0);
                pix("blast_143_66", 143, 66, 1'b1);
                pix("blast_1000_70", 1000, 70, 1'b0);
            end
            step();
        end
        check("held_strobes", 10'(strobes), 10'd1);
        $display("drop held: e_x=%0d e_y=%0d strobes=%0d", e_x, e_y, strobes);
        btn_drop = 1'b0;
        step();

        // Second press during ARMED with a new position is ignored.
        b_x = 10'd150; b_y = 10'd60;
        btn_drop = 1'b1; step();
        btn_drop = 1'b0; step();
        b_x = 10'd300; b_y = 10'd200;
        btn_drop = 1'b1; step();
        btn_drop = 1'b0;
        check("armed_e_x", e_x, 10'd143);
        check("armed_e_y", e_y, 10'd66);
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            if (explosion_SCEN) strobes++;
            step();
        end
        check("second_press_strobes", 10'(strobes), 10'd1);
        check("second_press_e_x", e_x, 10'd143);
        $display("second press: e_x=%0d strobes=%0d", e_x, strobes);

        // game_over sampled at edge k+5 aborts the bomb with no strobe.
        b_x = 10'd150; b_y = 10'd60;
        btn_drop = 1'b1; step();     // cycle k+1
        btn_drop = 1'b0;
        for (int i = 0; i < 4; i++) step();  // cycle k+5
        check("go_bomb_k5", {9'd0, bomb_active}, 10'd1);
        game_over = 1'b1; step();    // cycle k+6
        game_over = 1'b0;
        check("go_bomb_k6", {9'd0, bomb_active}, 10'd0);
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            if (explosion_SCEN) strobes++;
            step();
        end
        check("go_strobes", 10'(strobes), 10'd0);
        $display("game_over: bomb_active=%0d strobes=%0d", bomb_active, strobes);

        // Asynchronous reset mid-fuse restores reset values at once.
        b_x = 10'd300; b_y = 10'd60;
        btn_drop = 1'b1; step();
        btn_drop = 1'b0; step();
        check("snap_303", e_x, 10'd303);
        #2 reset = 1'b1;
        #1;
        check("async_rst_bomb", {9'd0, bomb_active}, 10'd0);
        check("async_rst_e_x", e_x, 10'd143);
        check("async_rst_e_y", e_y, 10'd34);
        step();
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            if (explosion_SCEN) strobes++;
            step();
        end
        check("rst_lost_strobe", 10'(strobes), 10'd0);
        $display("mid reset: e_x=%0d strobes=%0d", e_x, strobes);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bomb_controller.md
Name: bomb_controller

Overview:
- Upstream feeder of the enemy block: owns the player's single bomb from drop to detonation.
- Latches a grid-snapped bomb position from the player location on a drop button press and runs the fuse timer.
- Issues the one-cycle explosion strobe (explosion_SCEN) together with a stable blast centre (e_x, e_y) for enemy blocks to consume.
- Generates the bomb and plus-shaped blast pixel flags for the display mux in the top module.

Parameters:
- TICK_LIMIT, 25000000: clk cycles per timing tick; sized for 0.25 s at 100 MHz.
- FUSE_TICKS, 8: number of ticks spent in ARMED before detonation.
- EXPLODE_TICKS, 4: number of ticks the blast stays displayed.
- TILE, 16: tile size in pixels; must be a power of two.
- GRID_X0, 143: x origin of the tile grid, equal to the left display edge.
- GRID_Y0, 34: y origin of the tile grid, equal to the top display edge.
- ARM_NEG, 48: blast arm length left of / above the tile origin, in pixels.
- ARM_POS, 63: blast arm extent right of / below the tile origin, in pixels.

Ports:
- clk  input  1  system clock
- reset  input  1  game reset
- btn_drop  input  1  debounced drop button, level
- game_over  input  1  high forces the block back to idle
- b_x  input  10  bomberman x, top-left pixel
- b_y  input  10  bomberman y, top-left pixel
- v_x  input  10  current VGA pixel x
- v_y  input  10  current VGA pixel y
- e_x  output  10  latched bomb/blast tile x
- e_y  output  10  latched bomb/blast tile y
- explosion_SCEN  output  1  one-cycle detonation strobe
- bomb_active  output  1  bomb placed, fuse running
- blast_active  output  1  blast being displayed
- bomb_on  output  1  current pixel lies inside the bomb tile
- blast_on  output  1  current pixel lies inside the blast plus shape

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk.
  - State goes to IDLE.
  - e_x = GRID_X0, e_y = GRID_Y0.
  - explosion_SCEN, bomb_active and blast_active are 0.
  - Tick counter, tick count and btn_drop_q are cleared.
- Drop edge: drop_req = btn_drop & ~btn_drop_q, where btn_drop_q is btn_drop registered every cycle. Holding the button produces no repeat drop.
- Snap rule, per axis with 10-bit arithmetic:
  - e_x = (((b_x - GRID_X0) + TILE/2) & ~(TILE-1)) + GRID_X0.
  - e_y uses the same rule with b_y and GRID_Y0.
  - The result is rounded to the nearest tile.
- Tick counter:
  - Counts 0 to TICK_LIMIT-1; tick pulses on the terminal count.
  - Cleared on every state entry.
  - Tick count increments on each tick.
- FSM states:
  - IDLE:
    - On drop_req & ~game_over: latch e_x/e_y and go to ARMED on the same edge.
    - bomb_active is 1 from the next cycle.
  - ARMED:
    - On the tick with tick count == FUSE_TICKS-1, go to DETONATE.
    - Exactly FUSE_TICKS*TICK_LIMIT cycles are spent in ARMED.
    - drop_req is ignored (single bomb).
  - DETONATE:
    - Lasts exactly one cycle.
    - explosion_SCEN = 1, bomb_active = 0.
    - Next state is BLAST.
  - BLAST:
    - blast_active = 1 for EXPLODE_TICKS*TICK_LIMIT cycles, then IDLE.
    - drop_req is ignored.
- All status outputs are decoded from registered state. The exact-cycle counts above are normative.
- e_x/e_y:
  - Stable from the drop until the next accepted drop.
  - Valid on every cycle that explosion_SCEN = 1.
- game_over = 1 in any state: next state is IDLE and no explosion_SCEN is issued. A detonation landing on the same edge is suppressed.
- game_over has priority over drop_req.
- bomb_on = bomb_active & v_x in [e_x, e_x+TILE-1] & v_y in [e_y, e_y+TILE-1].
- blast_on = blast_active & (h_arm | v_arm):
  - h_arm: v_x+ARM_NEG >= e_x & v_x <= e_x+ARM_POS & v_y in [e_y, e_y+TILE-1].
  - v_arm: v_y+ARM_NEG >= e_y & v_y <= e_y+ARM_POS & v_x in [e_x, e_x+TILE-1].
  - Comparisons are done on the addend side so that e_x-ARM_NEG never underflows near the left/top walls.
- bomb_on and blast_on are combinational with zero latency relative to v_x/v_y.
- Reset asserted mid-operation: immediate return to the reset values; a pending detonation is lost.

Test Plan (TICK_LIMIT=4, FUSE_TICKS=3, EXPLODE_TICKS=2):
- Reset then idle 20 cycles -> e_x=143, e_y=34, all flags 0, no strobe.
- Drop with b_x=150, b_y=60 (rising edge at cycle k) -> e_x=143, e_y=66; bomb_active=1 cycles k+1..k+12; explosion_SCEN=1 only at k+13; blast_active=1 cycles k+14..k+21; IDLE at k+22.
- btn_drop held high for 40 cycles -> exactly one detonation.
- Second press during ARMED with a new b_x -> e_x unchanged, no second strobe.
- game_over pulsed at cycle k+5 after a drop -> bomb_active=0 at k+6, explosion_SCEN never asserts.
- Blast at e_x=143, e_y=66 -> blast_on=1 at (v_x=206, v_y=70) and at (143, 129); blast_on=0 at (207, 70) and at (160, 82); v_x=143, v_y=66 is 1; no false hit from underflow at (v_x=1000, v_y=70).
